// File: rtl/next_addr_unit.sv
// Program counter and next-address unit for the MicroMIPS datapath, with a fetch handshake.
// Define JR_MISALIGN_TRAP_EN to trap a jr to a non-word-aligned register value.
module next_addr_unit #(
  parameter int unsigned       ADDR_W       = 30,
  parameter logic [ADDR_W-1:0] RESET_ADDR   = '0,
  parameter logic [ADDR_W-1:0] SYSCALL_ADDR = ADDR_W'(32'h0000_0100)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        brtype_i,
  input  logic [1:0]        pcsrc_i,
  input  logic              ctl_valid_i,
  input  logic [31:0]       rs_data_i,
  input  logic [31:0]       rt_data_i,
  input  logic [15:0]       imm_i,
  input  logic [25:0]       jta_i,
  input  logic              imem_ack_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] incr_pc_o,
  output logic              instr_done_o,
  output logic              taken_o,
  output logic              misalign_o
);

  typedef enum logic [1:0] {StResetHold, StFetch, StExec} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] incr_pc;
  logic [ADDR_W-1:0] pc_next;
  logic              imem_req_q;
  logic              instr_done_q;
  logic              taken_q;
  logic              next_taken;
  logic              br_cond;
`ifdef JR_MISALIGN_TRAP_EN
  logic              misalign_q;
  logic              next_mis;
`endif

  assign incr_pc = pc_q + ADDR_W'(1);

  // brtype is decoded only under pcsrc==00 so an unknown brtype never reaches pc_q.
  always_comb begin
    pc_next    = incr_pc;
    next_taken = 1'b0;
    br_cond    = 1'b0;
`ifdef JR_MISALIGN_TRAP_EN
    next_mis   = 1'b0;
`endif
    case (pcsrc_i)
      2'b00: begin
        case (brtype_i)
          2'b01:   br_cond = (rs_data_i == rt_data_i);
          2'b10:   br_cond = (rs_data_i != rt_data_i);
          2'b11:   br_cond = rs_data_i[31];
          default: br_cond = 1'b0;
        endcase
        if (br_cond) begin
          pc_next    = incr_pc + {{(ADDR_W-16){imm_i[15]}}, imm_i};
          next_taken = 1'b1;
        end
      end
      2'b01: begin
        pc_next    = {pc_q[ADDR_W-1:26], jta_i};
        next_taken = 1'b1;
      end
      2'b10: begin
        pc_next    = rs_data_i[ADDR_W+1:2];
        next_taken = 1'b1;
`ifdef JR_MISALIGN_TRAP_EN
        if (rs_data_i[1:0] != 2'b00) begin
          pc_next  = SYSCALL_ADDR;
          next_mis = 1'b1;
        end
`endif
      end
      default: begin
        pc_next    = SYSCALL_ADDR;
        next_taken = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StResetHold;
      pc_q         <= RESET_ADDR;
      imem_req_q   <= 1'b0;
      instr_done_q <= 1'b0;
      taken_q      <= 1'b0;
`ifdef JR_MISALIGN_TRAP_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      instr_done_q <= 1'b0;
      taken_q      <= 1'b0;
`ifdef JR_MISALIGN_TRAP_EN
      misalign_q   <= 1'b0;
`endif
      case (state_q)
        StResetHold: begin
          state_q    <= StFetch;
          imem_req_q <= 1'b1;
        end
        StFetch: begin
          if (imem_ack_i) begin
            state_q    <= StExec;
            imem_req_q <= 1'b0;
          end
        end
        StExec: begin
          if (ctl_valid_i) begin
            pc_q         <= pc_next;
            instr_done_q <= 1'b1;
            taken_q      <= next_taken;
`ifdef JR_MISALIGN_TRAP_EN
            misalign_q   <= next_mis;
`endif
            state_q      <= StFetch;
            imem_req_q   <= 1'b1;
          end
        end
        default: begin
          state_q    <= StResetHold;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign pc_o         = pc_q;
  assign imem_addr_o  = pc_q;
  assign incr_pc_o    = incr_pc;
  assign imem_req_o   = imem_req_q;
  assign instr_done_o = instr_done_q;
  assign taken_o      = taken_q;
`ifdef JR_MISALIGN_TRAP_EN
  assign misalign_o   = misalign_q;
`else
  assign misalign_o   = 1'b0;
`endif

endmodule
